// File: rtl/connect4_drop_win.sv
// Connect-Four game core: button edge pulses, column cursor, piece drop, win scan and blink.
// Optional DROP_ANIM_EN animates the falling piece through currRow, FALL_TICKS cycles per row.
module connect4_drop_win #(
    parameter int BLINK_MAX  = 1525,
    parameter int FALL_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        left,
    input  logic        right,
    input  logic        confirm,
    output logic [41:0] board0,
    output logic [41:0] board1,
    output logic [41:0] winMask,
    output logic [2:0]  positionOut,
    output logic        currentPlayer,
    output logic [5:0]  currRow,
    output logic        confirmPulse,
    output logic        dropDone,
    output logic        weHaveAWinner
);

    localparam int BW = $clog2(BLINK_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_DROP, S_CHECK, S_NEXT, S_OVER} state_t;
    state_t state, state_nxt;

    logic          left_q, right_q, confirm_q;
    logic          left_p, right_p, confirm_p;
    logic [41:0]   b0, b1, mover, cand, match, hide, drop_mask;
    logic [2:0]    tgt_row, tgt_col, free_row;
    logic [5:0]    drop_idx;
    logic          col_free, found, blink_on;
    logic [BW-1:0] blink_cnt;

    function automatic logic [41:0] line_mask(input int start, input int step);
        logic [41:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[start + k * step] = 1'b1;
        return m;
    endfunction

    // Buttons only act while the game is waiting for a selection.
    assign left_p       = left & ~left_q & (state == S_IDLE);
    assign right_p      = right & ~right_q & (state == S_IDLE);
    assign confirm_p    = confirm & ~confirm_q & (state == S_IDLE);
    assign confirmPulse = confirm_p;

    always_comb begin
        col_free = 1'b0;
        free_row = '0;
        for (int r = 5; r >= 0; r--) begin
            if (!b0[r * 7 + int'(positionOut)] && !b1[r * 7 + int'(positionOut)]) begin
                col_free = 1'b1;
                free_row = 3'(r);
            end
        end
    end

    // Scan order decides which line is reported when several complete at once.
    always_comb begin
        mover = currentPlayer ? b1 : b0;
        found = 1'b0;
        match = '0;
        cand  = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) begin
                cand = line_mask(r * 7 + c, 1);
                if (!found && (mover & cand) == cand) begin found = 1'b1; match = cand; end
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 7; c++) begin
                cand = line_mask(r * 7 + c, 7);
                if (!found && (mover & cand) == cand) begin found = 1'b1; match = cand; end
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                cand = line_mask(r * 7 + c, 8);
                if (!found && (mover & cand) == cand) begin found = 1'b1; match = cand; end
            end
        for (int r = 0; r < 3; r++)
            for (int c = 3; c < 7; c++) begin
                cand = line_mask(r * 7 + c, 6);
                if (!found && (mover & cand) == cand) begin found = 1'b1; match = cand; end
            end
    end

`ifdef DROP_ANIM_EN
    localparam int TW = $clog2(FALL_TICKS + 1);
    logic [2:0]    anim_row;
    logic [TW-1:0] tick_cnt;
    assign currRow = (state == S_DROP) ? (6'd1 << anim_row) : 6'd0;
`else
    assign currRow = 6'd0;
`endif

    always_comb begin
        state_nxt = state;
        dropDone  = 1'b0;
        case (state)
            S_IDLE:  if (confirm_p && col_free) state_nxt = S_DROP;
            S_DROP: begin
`ifdef DROP_ANIM_EN
                if (tick_cnt == '0 && anim_row == tgt_row) begin
                    dropDone  = 1'b1;
                    state_nxt = S_CHECK;
                end
`else
                dropDone  = 1'b1;
                state_nxt = S_CHECK;
`endif
            end
            S_CHECK: state_nxt = found ? S_OVER : S_NEXT;
            S_NEXT:  state_nxt = S_IDLE;
            S_OVER:  state_nxt = S_OVER;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign drop_idx  = 6'(tgt_row) * 6'd7 + 6'(tgt_col);
    assign drop_mask = 42'd1 << drop_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            confirm_q     <= 1'b0;
            b0            <= '0;
            b1            <= '0;
            winMask       <= '0;
            positionOut   <= '0;
            currentPlayer <= 1'b0;
            weHaveAWinner <= 1'b0;
            tgt_row       <= '0;
            tgt_col       <= '0;
            blink_cnt     <= '0;
`ifdef DROP_ANIM_EN
            anim_row      <= '0;
            tick_cnt      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            left_q    <= left;
            right_q   <= right;
            confirm_q <= confirm;
            if (left_p && !right_p && positionOut != 3'd0)
                positionOut <= positionOut - 3'd1;
            else if (right_p && !left_p && positionOut != 3'd6)
                positionOut <= positionOut + 3'd1;
            if (state == S_IDLE && confirm_p && col_free) begin
                tgt_col <= positionOut;
                tgt_row <= free_row;
`ifdef DROP_ANIM_EN
                anim_row <= 3'd5;
                tick_cnt <= TW'(FALL_TICKS - 1);
`endif
            end
`ifdef DROP_ANIM_EN
            if (state == S_DROP) begin
                if (tick_cnt != '0) begin
                    tick_cnt <= tick_cnt - 1'b1;
                end else if (anim_row != tgt_row) begin
                    anim_row <= anim_row - 3'd1;
                    tick_cnt <= TW'(FALL_TICKS - 1);
                end
            end
`endif
            if (dropDone) begin
                if (currentPlayer) b1 <= b1 | drop_mask;
                else               b0 <= b0 | drop_mask;
            end
            if (state == S_CHECK && found) begin
                weHaveAWinner <= 1'b1;
                winMask       <= match;
            end
            if (state == S_NEXT) currentPlayer <= ~currentPlayer;
            if (state == S_OVER)
                blink_cnt <= (blink_cnt == BW'(BLINK_MAX - 1)) ? '0 : blink_cnt + 1'b1;
        end
    end

    // winMask stays zero until a win, so hiding is harmless before GAME_OVER.
    assign blink_on = blink_cnt < BW'(BLINK_MAX / 2);
    assign hide     = blink_on ? 42'd0 : winMask;
    assign board0   = currentPlayer ? b0 : (b0 & ~hide);
    assign board1   = currentPlayer ? (b1 & ~hide) : b1;

endmodule

// File: tb/tb_connect4_drop_win.sv
// Bench for connect4_drop_win: drop scoreboard, cursor limits, full column, wins, blink and reset.
`timescale 1ns/1ps
module tb_connect4_drop_win;

    localparam int BLINK_MAX = 1525;

    logic        clk = 1'b0;
    logic        reset, left, right, confirm;
    logic [41:0] board0, board1, winMask;
    logic [2:0]  positionOut;
    logic        currentPlayer, confirmPulse, dropDone, weHaveAWinner;
    logic [5:0]  currRow;

    typedef struct { bit player; int idx; } drop_t;
    drop_t sb[$];

    int          checks = 0, errors = 0;
    logic [41:0] mb0, mb1;
    bit          mplayer, mwin;
    int          mpos;

    connect4_drop_win #(.BLINK_MAX(BLINK_MAX), .FALL_TICKS(8)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .confirm(confirm),
        .board0(board0), .board1(board1), .winMask(winMask), .positionOut(positionOut),
        .currentPlayer(currentPlayer), .currRow(currRow), .confirmPulse(confirmPulse),
        .dropDone(dropDone), .weHaveAWinner(weHaveAWinner)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic bit has_four(input logic [41:0] b);
        int dr[4];
        int dc[4];
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok;
                    ok = 1;
                    for (int k = 0; k < 4; k++) begin
                        int rr, cc;
                        rr = r + dr[d] * k;
                        cc = c + dc[d] * k;
                        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 0;
                        else if (!b[rr * 7 + cc]) ok = 0;
                    end
                    if (ok) return 1;
                end
        return 0;
    endfunction

    task automatic do_reset();
        reset = 0; left = 0; right = 0; confirm = 0;
        repeat (20) @(negedge clk);
        reset = 1;
        mb0 = '0; mb1 = '0; mplayer = 0; mwin = 0; mpos = 0;
        sb.delete();
    endtask

    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: left = 1;
            1: right = 1;
            2: confirm = 1;
            default: begin left = 1; right = 1; end
        endcase
        if (!mwin) begin
            if (which == 0 && mpos > 0) mpos--;
            if (which == 1 && mpos < 6) mpos++;
        end
        @(negedge clk);
        left = 0; right = 0; confirm = 0;
    endtask

    task automatic move_to(input int col);
        while (mpos != col) press(mpos < col ? 1 : 0);
    endtask

    task automatic do_drop(input int col);
        int    idx;
        bit    seen, got;
        drop_t e;
        move_to(col);
        #1;
        checks++;
        if (positionOut !== 3'(col)) begin
            errors++;
            $display("FAIL cursor_before_drop: got %0d want %0d", positionOut, col);
        end
        idx = -1;
        for (int r = 0; r < 6; r++)
            if (idx < 0 && !mb0[r * 7 + col] && !mb1[r * 7 + col]) idx = r * 7 + col;
        if (idx >= 0 && !mwin) begin
            e.player = mplayer; e.idx = idx; sb.push_back(e);
        end
        press(2);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            if (dropDone === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (seen && sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_drop: col %0d got dropDone 1 want 0", col);
        end else if (!seen && sb.size() != 0) begin
            errors++;
            $display("FAIL missing_drop: col %0d got no dropDone want pulse", col);
            sb.delete();
        end
        if (seen && sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); #1;
            checks++;
            if (dropDone !== 1'b0) begin
                errors++;
                $display("FAIL drop_pulse_width: got dropDone %b want 0", dropDone);
            end
            got = e.player ? board1[e.idx] : board0[e.idx];
            checks++;
            if (got !== 1'b1) begin
                errors++;
                $display("FAIL board_bit: player %0d idx %0d got %b want 1", e.player, e.idx, got);
            end
            if (e.player) mb1[e.idx] = 1'b1; else mb0[e.idx] = 1'b1;
            mwin = has_four(e.player ? mb1 : mb0);
            if (!mwin) mplayer = ~mplayer;
            repeat (2) @(negedge clk);
        end
        #1;
        checks++;
        if (currentPlayer !== mplayer) begin
            errors++;
            $display("FAIL player_after_drop: got %0d want %0d", currentPlayer, mplayer);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 5;
        if (board0 !== '0 || board1 !== '0) begin
            errors++; $display("FAIL reset_boards: got %h %h want 0", board0, board1);
        end
        if (positionOut !== 3'd0) begin
            errors++; $display("FAIL reset_pos: got %0d want 0", positionOut);
        end
        if (currentPlayer !== 1'b0) begin
            errors++; $display("FAIL reset_player: got %0d want 0", currentPlayer);
        end
        if (weHaveAWinner !== 1'b0 || winMask !== '0) begin
            errors++; $display("FAIL reset_win: got %b %h want 0", weHaveAWinner, winMask);
        end
        if (dropDone !== 1'b0 || currRow !== 6'd0) begin
            errors++; $display("FAIL reset_drop: got %b %h want 0", dropDone, currRow);
        end
    endtask

    task automatic test_first_drop();
        do_reset();
        do_drop(0);
        #1;
        checks++;
        if (board0 !== 42'd1 || board1 !== 42'd0) begin
            errors++; $display("FAIL first_drop_boards: got %h %h want 1 0", board0, board1);
        end
    endtask

    task automatic test_cursor();
        int drops;
        do_reset();
        repeat (6) press(1);
        #1; checks++;
        if (positionOut !== 3'd6) begin errors++; $display("FAIL cursor_six_right: got %0d want 6", positionOut); end
        press(1);
        #1; checks++;
        if (positionOut !== 3'd6) begin errors++; $display("FAIL cursor_sat_right: got %0d want 6", positionOut); end
        repeat (5) press(0);
        #1; checks++;
        if (positionOut !== 3'd1) begin errors++; $display("FAIL cursor_five_left: got %0d want 1", positionOut); end
        press(3);
        #1; checks++;
        if (positionOut !== 3'd1) begin errors++; $display("FAIL cursor_both: got %0d want 1", positionOut); end
        repeat (3) press(0);
        #1; checks++;
        if (positionOut !== 3'd0) begin errors++; $display("FAIL cursor_sat_left: got %0d want 0", positionOut); end
        press(1);
        drops = 0;
        @(negedge clk);
        confirm = 1;
        for (int i = 0; i < 10; i++) begin
            #1; if (dropDone === 1'b1) drops++;
            @(negedge clk);
        end
        confirm = 0;
        for (int i = 0; i < 5; i++) begin
            #1; if (dropDone === 1'b1) drops++;
            @(negedge clk);
        end
        #1; checks += 3;
        if (drops != 1) begin errors++; $display("FAIL held_confirm_drops: got %0d want 1", drops); end
        if (board0 !== 42'h2) begin errors++; $display("FAIL held_confirm_board: got %h want 2", board0); end
        if (currentPlayer !== 1'b1) begin errors++; $display("FAIL held_confirm_player: got %0d want 1", currentPlayer); end
    endtask

    task automatic test_column_fill();
        logic [41:0] want0, want1;
        bit          any;
        do_reset();
        repeat (6) do_drop(3);
        want0 = '0; want1 = '0;
        for (int r = 0; r < 6; r++)
            if (r % 2 == 0) want0[r * 7 + 3] = 1'b1; else want1[r * 7 + 3] = 1'b1;
        #1; checks++;
        if (board0 !== want0 || board1 !== want1) begin
            errors++; $display("FAIL column_fill: got %h %h want %h %h", board0, board1, want0, want1);
        end
        @(negedge clk);
        confirm = 1;
        #1; checks++;
        if (confirmPulse !== 1'b1) begin errors++; $display("FAIL full_col_pulse: got %b want 1", confirmPulse); end
        any = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); confirm = 0;
            #1; if (dropDone === 1'b1) any = 1;
        end
        checks += 2;
        if (any) begin errors++; $display("FAIL full_col_drop: got dropDone 1 want 0"); end
        if (currentPlayer !== mplayer) begin
            errors++; $display("FAIL full_col_player: got %0d want %0d", currentPlayer, mplayer);
        end
    endtask

    task automatic test_horizontal_win();
        int  cols[7];
        int  n;
        bit  any;
        cols = '{0, 0, 1, 1, 2, 2, 3};
        do_reset();
        foreach (cols[i]) do_drop(cols[i]);
        #1; checks += 3;
        if (weHaveAWinner !== 1'b1) begin errors++; $display("FAIL hwin_flag: got %b want 1", weHaveAWinner); end
        if (winMask !== 42'hF) begin errors++; $display("FAIL hwin_mask: got %h want f", winMask); end
        if (currentPlayer !== 1'b0) begin errors++; $display("FAIL hwin_player: got %0d want 0", currentPlayer); end
        @(negedge clk);
        confirm = 1;
        #1; checks++;
        if (confirmPulse !== 1'b0) begin errors++; $display("FAIL over_confirm_gated: got %b want 0", confirmPulse); end
        any = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); confirm = 0;
            #1; if (dropDone === 1'b1) any = 1;
        end
        press(1);
        #1; checks += 3;
        if (any) begin errors++; $display("FAIL over_drop: got dropDone 1 want 0"); end
        if (positionOut !== 3'd3) begin errors++; $display("FAIL over_cursor: got %0d want 3", positionOut); end
        if (board1 !== mb1 || board0[41:4] !== mb0[41:4]) begin
            errors++; $display("FAIL over_other_cells: got %h %h want %h %h", board0, board1, mb0, mb1);
        end
        n = 0;
        while (board0[3:0] !== 4'hF && n < BLINK_MAX + 5) begin @(negedge clk); #1; n++; end
        while (board0[3:0] !== 4'h0 && n < 2 * BLINK_MAX + 10) begin @(negedge clk); #1; n++; end
        checks++;
        if (board0[3:0] !== 4'h0) begin
            errors++; $display("FAIL blink_hide_seen: got %h want 0", board0[3:0]);
        end else begin
            n = 0;
            while (board0[3:0] === 4'h0 && n < BLINK_MAX + 5) begin @(negedge clk); #1; n++; end
            checks++;
            if (n != BLINK_MAX - BLINK_MAX / 2 || board0[3:0] !== 4'hF) begin
                errors++; $display("FAIL blink_hidden_len: got %0d cycles then %h want %0d then f", n, board0[3:0], BLINK_MAX - BLINK_MAX / 2);
            end
            n = 0;
            while (board0[3:0] === 4'hF && n < BLINK_MAX + 5) begin @(negedge clk); #1; n++; end
            checks++;
            if (n != BLINK_MAX / 2) begin
                errors++; $display("FAIL blink_shown_len: got %0d want %0d", n, BLINK_MAX / 2);
            end
        end
    endtask

    task automatic test_vertical_win();
        int cols[7];
        cols = '{6, 5, 6, 5, 6, 5, 6};
        do_reset();
        foreach (cols[i]) do_drop(cols[i]);
        #1; checks += 2;
        if (weHaveAWinner !== 1'b1) begin errors++; $display("FAIL vwin_flag: got %b want 1", weHaveAWinner); end
        if (winMask !== ((42'd1 << 6) | (42'd1 << 13) | (42'd1 << 20) | (42'd1 << 27))) begin
            errors++; $display("FAIL vwin_mask: got %h want 8102040", winMask);
        end
    endtask

    task automatic test_diagonal_win();
        int cols[11];
        cols = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
        do_reset();
        foreach (cols[i]) do_drop(cols[i]);
        #1; checks += 3;
        if (weHaveAWinner !== 1'b1) begin errors++; $display("FAIL dwin_flag: got %b want 1", weHaveAWinner); end
        if (winMask !== ((42'd1 << 0) | (42'd1 << 8) | (42'd1 << 16) | (42'd1 << 24))) begin
            errors++; $display("FAIL dwin_mask: got %h want 1010101", winMask);
        end
        if (currentPlayer !== 1'b0) begin errors++; $display("FAIL dwin_player: got %0d want 0", currentPlayer); end
    endtask

    task automatic test_reset_in_over();
        repeat (900) @(negedge clk);
        reset = 0;
        @(negedge clk); #1;
        checks++;
        if ({board0, board1, winMask, positionOut, currentPlayer, currRow, dropDone, weHaveAWinner, confirmPulse} !== '0) begin
            errors++; $display("FAIL reset_in_over: got %h %h %h pos %0d pl %0d win %b want all 0", board0, board1, winMask, positionOut, currentPlayer, weHaveAWinner);
        end
        @(negedge clk);
        reset = 1;
        mb0 = '0; mb1 = '0; mplayer = 0; mwin = 0; mpos = 0;
        repeat (3) @(negedge clk); #1;
        checks++;
        if ({board0, board1, winMask, positionOut, currentPlayer, weHaveAWinner} !== '0) begin
            errors++; $display("FAIL after_reset_release: got %h %h %h pos %0d want all 0", board0, board1, winMask, positionOut);
        end
        do_drop(2);
    endtask

    initial begin
        reset = 0; left = 0; right = 0; confirm = 0;
        test_reset();
        test_first_drop();
        test_cursor();
        test_column_fill();
        test_horizontal_win();
        test_vertical_win();
        test_diagonal_win();
        test_reset_in_over();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
